mem_arbiter: RTL

- Sequences the single shared word-wide memory port for the LC-3b core.
- Shares that port between two requesters: the CPU memory interface (MAR/MDR side, MEMEN in, R out) and a DMA/IO requester.
- Inserts a fixed number of wait states per access, drives the memory strobes and byte enables, and returns the ready pulse R to the control FSM.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_rr_arb.sv | 36 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the LC-3b memory port arbiter: FSM states, owner IDs
// and byte-enable patterns.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;

    // Odd byte addresses live in the high lane of the memory word.
    function automatic logic [1:0] byte_enables(input logic byte_acc, input logic addr_lsb);
        if (!byte_acc) begin
            return BE_WORD;
        end
        return addr_lsb ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin grant between the CPU and DMA requesters; remembers
// the last owner so that simultaneous requests alternate.
module mem_rr_arb
    import mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_cpu,
    input  logic req_dma,
    input  logic enable,
    output logic grant_valid,
    output logic grant_owner
);

    logic last_grant;

    always_comb begin
        grant_valid = req_cpu || req_dma;
        grant_owner = OWN_CPU;
        if (req_cpu && req_dma) begin
            grant_owner = (last_grant == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end else if (req_dma) begin
            grant_owner = OWN_DMA;
        end
    end

    // Starting from DMA hands the CPU the first tie after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= OWN_DMA;
        end else if (enable && grant_valid) begin
            last_grant <= grant_owner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences the shared LC-3b memory port between the CPU (MAR/MDR) and a DMA
// requester, inserting WAIT_CYCLES wait states and returning R / ack pulses.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              cpu_we,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_r,
    output logic              cpu_unaligned,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [15:0]       dma_wdata,
    output logic [15:0]       dma_rdata,
    output logic              dma_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_next;
    logic [3:0]        count;
    logic              owner;
    logic              we_r;
    logic              unaligned_r;
    logic [1:0]        be_r;
    logic [ADDR_W-2:0] addr_r;
    logic [15:0]       wdata_r;

    logic              arb_enable;
    logic              grant_valid;
    logic              grant_owner;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic              sel_we;
    logic              sel_byte;

    assign arb_enable = (state == IDLE);

    mem_rr_arb u_rr_arb (
        .clk         (clk),
        .reset       (reset),
        .req_cpu     (cpu_en),
        .req_dma     (dma_req),
        .enable      (arb_enable),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // DMA accesses are always word-wide, so only the CPU can select a byte.
    assign sel_addr  = (grant_owner == OWN_DMA) ? dma_addr  : cpu_addr;
    assign sel_wdata = (grant_owner == OWN_DMA) ? dma_wdata : cpu_wdata;
    assign sel_we    = (grant_owner == OWN_DMA) ? dma_we    : cpu_we;
    assign sel_byte  = (grant_owner == OWN_CPU) && cpu_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        mem_ce        = 1'b0;
        mem_we        = 1'b0;
        mem_be        = 2'b00;
        mem_addr      = '0;
        mem_wdata     = 16'h0000;
        cpu_r         = 1'b0;
        cpu_unaligned = 1'b0;
        dma_ack       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_ce    = 1'b1;
                mem_we    = we_r;
                mem_be    = be_r;
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
                if (count == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                cpu_r         = (owner == OWN_CPU);
                cpu_unaligned = (owner == OWN_CPU) && unaligned_r;
                dma_ack       = (owner == OWN_DMA);
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte writes replicate the low data byte on both lanes; the byte enable
    // picks which lane the memory actually stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= 4'd0;
            owner       <= OWN_CPU;
            we_r        <= 1'b0;
            unaligned_r <= 1'b0;
            be_r        <= 2'b00;
            addr_r      <= '0;
            wdata_r     <= 16'h0000;
            cpu_rdata   <= 16'h0000;
            dma_rdata   <= 16'h0000;
        end else begin
            if (state == IDLE && grant_valid) begin
                count       <= WAIT_LOAD;
                owner       <= grant_owner;
                we_r        <= sel_we;
                be_r        <= byte_enables(sel_byte, sel_addr[0]);
                addr_r      <= sel_addr[ADDR_W-1:1];
                wdata_r     <= sel_byte ? {sel_wdata[7:0], sel_wdata[7:0]} : sel_wdata;
                unaligned_r <= (grant_owner == OWN_CPU) && !cpu_byte && sel_addr[0];
            end else if (state == ACCESS) begin
                count <= count - 4'd1;
                if (count == 4'd1 && !we_r) begin
                    if (owner == OWN_DMA) begin
                        dma_rdata <= mem_rdata;
                    end else begin
                        cpu_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule
